// File: rtl/multipli_booth_pkg.sv
// Shared types and width helpers for the sequential radix-2 Booth multiplier.
package multipli_booth_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    function automatic int unsigned prod_width(input int unsigned a_bits,
                                               input int unsigned b_bits);
        return a_bits + b_bits;
    endfunction

    // Counter must hold B_BITS+1 iterations.
    function automatic int unsigned cnt_width(input int unsigned b_bits);
        return $clog2(b_bits + 2);
    endfunction

endpackage

// File: rtl/multipli_booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of the multiplicand, then arithmetic shift.
module multipli_booth_step #(
    parameter int unsigned A_BITS = 8,
    parameter int unsigned B_BITS = 8
) (
    input  logic [A_BITS:0] p_hi,
    input  logic [B_BITS:0] p_lo,
    input  logic            q_m1,
    input  logic [A_BITS:0] a_ext,
    output logic [A_BITS:0] p_hi_nxt,
    output logic [B_BITS:0] p_lo_nxt,
    output logic            q_m1_nxt
);

    logic [A_BITS:0] sum;

    always_comb begin
        sum = p_hi;
        case ({p_lo[0], q_m1})
            2'b01:   sum = p_hi + a_ext;
            2'b10:   sum = p_hi - a_ext;
            default: sum = p_hi;
        endcase
    end

    // Shift of {sum, p_lo, q_m1} right by one, replicating the sign of sum.
    assign p_hi_nxt = {sum[A_BITS], sum[A_BITS:1]};
    assign p_lo_nxt = {sum[0], p_lo[B_BITS:1]};
    assign q_m1_nxt = p_lo[0];

endmodule

// File: rtl/multipli_booth_seq.sv
// Sequential signed/unsigned Booth multiplier behind a START / END_MULT handshake.
module multipli_booth_seq
    import multipli_booth_pkg::*;
#(
    parameter int unsigned A_BITS = 8,
    parameter int unsigned B_BITS = 8
) (
    input  logic                                     CLK,
    input  logic                                     RESET,
    input  logic                                     START,
    input  logic                                     SIGNED_MODE,
    input  logic [A_BITS-1:0]                        A,
    input  logic [B_BITS-1:0]                        B,
    output logic [prod_width(A_BITS, B_BITS)-1:0]    S,
    output logic                                     END_MULT,
    output logic                                     BUSY
);

    localparam int unsigned PW   = prod_width(A_BITS, B_BITS);
    localparam int unsigned CntW = cnt_width(B_BITS);

    state_e            state_q, state_d;
    logic [A_BITS:0]   a_ext_q, a_ext_d;
    logic [A_BITS:0]   p_hi_q, p_hi_d;
    logic [B_BITS:0]   p_lo_q, p_lo_d;
    logic              q_m1_q, q_m1_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]     s_q, s_d;
    logic              end_q, end_d;
    logic              busy_q, busy_d;

    logic [A_BITS:0]   step_p_hi;
    logic [B_BITS:0]   step_p_lo;
    logic              step_q_m1;
    logic [PW+1:0]     step_prod;
    logic              unused_prod_top;

    multipli_booth_step #(
        .A_BITS (A_BITS),
        .B_BITS (B_BITS)
    ) u_step (
        .p_hi     (p_hi_q),
        .p_lo     (p_lo_q),
        .q_m1     (q_m1_q),
        .a_ext    (a_ext_q),
        .p_hi_nxt (step_p_hi),
        .p_lo_nxt (step_p_lo),
        .q_m1_nxt (step_q_m1)
    );

    // Top two bits are pure sign extension of the exact product.
    assign step_prod       = {step_p_hi, step_p_lo};
    assign unused_prod_top = ^step_prod[PW+1:PW];

    always_comb begin
        state_d = state_q;
        a_ext_d = a_ext_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        q_m1_d  = q_m1_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        end_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (START) begin
                    state_d = StCalc;
                    a_ext_d = {SIGNED_MODE & A[A_BITS-1], A};
                    p_hi_d  = '0;
                    p_lo_d  = {SIGNED_MODE & B[B_BITS-1], B};
                    q_m1_d  = 1'b0;
                    cnt_d   = CntW'(B_BITS + 1);
                end
            end
            StCalc: begin
                p_hi_d = step_p_hi;
                p_lo_d = step_p_lo;
                q_m1_d = step_q_m1;
                cnt_d  = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                    s_d     = step_prod[PW-1:0];
                    end_d   = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
            a_ext_q <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            q_m1_q  <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            end_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_ext_q <= a_ext_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            q_m1_q  <= q_m1_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            end_q   <= end_d;
            busy_q  <= busy_d;
        end
    end

    assign S        = s_q;
    assign END_MULT = end_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_multipli_booth_seq.sv
// Self-checking bench: an 8x8 and a 12x5 instance checked against integer-product reference.
module tb_multipli_booth_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start8, sm8;
    logic [7:0]  a8, b8;
    logic [15:0] s8;
    logic        end8, busy8;

    logic        start12, sm12;
    logic [11:0] a12;
    logic [4:0]  b12;
    logic [16:0] s12;
    logic        end12, busy12;

    int n_cmp = 0;
    int n_err = 0;

    multipli_booth_seq #(
        .A_BITS (8),
        .B_BITS (8)
    ) dut8 (
        .CLK         (clk),
        .RESET       (rst),
        .START       (start8),
        .SIGNED_MODE (sm8),
        .A           (a8),
        .B           (b8),
        .S           (s8),
        .END_MULT    (end8),
        .BUSY        (busy8)
    );

    multipli_booth_seq #(
        .A_BITS (12),
        .B_BITS (5)
    ) dut12 (
        .CLK         (clk),
        .RESET       (rst),
        .START       (start12),
        .SIGNED_MODE (sm12),
        .A           (a12),
        .B           (b12),
        .S           (s12),
        .END_MULT    (end12),
        .BUSY        (busy12)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: interpret operands as integers, multiply, truncate to the product width.
    function automatic logic [63:0] model(input longint a, input longint b, input bit sm,
                                          input int wa, input int wb);
        longint av, bv, p;
        av = a & ((longint'(1) << wa) - 1);
        bv = b & ((longint'(1) << wb) - 1);
        if (sm && av[wa-1]) av = av - (longint'(1) << wa);
        if (sm && bv[wb-1]) bv = bv - (longint'(1) << wb);
        p = av * bv;
        return p & ((longint'(1) << (wa + wb)) - 1);
    endfunction

    function automatic logic sel_end(input bit big);
        return big ? end12 : end8;
    endfunction

    function automatic logic sel_busy(input bit big);
        return big ? busy12 : busy8;
    endfunction

    function automatic logic [63:0] sel_s(input bit big);
        return big ? 64'(s12) : 64'(s8);
    endfunction

    // Single operation with a one-cycle START; operands scrambled right after capture.
    task automatic run_op(input bit big, input logic [63:0] a, input logic [63:0] b,
                          input bit sm, input string tag, input logic [63:0] exp);
        int lat;
        int busy_n;
        int wb;
        wb = big ? 5 : 8;
        @(negedge clk);
        if (big) begin
            start12 = 1'b1; a12 = a[11:0]; b12 = b[4:0]; sm12 = sm;
        end else begin
            start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; sm8 = sm;
        end
        @(negedge clk);
        if (big) begin
            start12 = 1'b0; a12 = 12'($urandom); b12 = 5'($urandom); sm12 = ~sm;
        end else begin
            start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = ~sm;
        end
        lat = 0;
        busy_n = 0;
        while (!sel_end(big) && lat < 40) begin
            if (sel_busy(big)) busy_n++;
            @(negedge clk);
            lat++;
        end
        if (sel_busy(big)) busy_n++;
        check({tag, "_lat"}, 64'(lat), 64'(wb + 1));
        check({tag, "_s"}, sel_s(big), exp);
        check({tag, "_busy"}, 64'(busy_n), 64'(wb + 2));
        @(negedge clk);
        check({tag, "_endlow"}, 64'(sel_end(big)), 64'd0);
        check({tag, "_idle"}, 64'(sel_busy(big)), 64'd0);
        check({tag, "_hold"}, sel_s(big), exp);
    endtask

    initial begin
        logic [7:0]  ca, cb, na, nb;
        bit          csm, nsm;
        logic [63:0] e1, e2;
        int          ends;

        rst = 1'b1;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        start12 = 1'b0; sm12 = 1'b0; a12 = '0; b12 = '0;
        repeat (3) @(negedge clk);
        check("rst_s8", 64'(s8), 64'd0);
        check("rst_end8", 64'(end8), 64'd0);
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_s12", 64'(s12), 64'd0);
        check("rst_busy12", 64'(busy12), 64'd0);
        rst = 1'b0;

        run_op(1'b0, -45, 96, 1'b1, "neg45x96", 64'hEF20);
        run_op(1'b0, -128, -128, 1'b1, "mneg_sq", 64'h4000);
        run_op(1'b0, -128, 127, 1'b1, "mneg_x127", 64'hC080);
        run_op(1'b0, 8'hFF, 8'hFF, 1'b0, "umax_sq", 64'hFE01);
        run_op(1'b0, 8'hFF, 8'hFF, 1'b1, "m1_sq", 64'h0001);
        run_op(1'b1, -2048, -16, 1'b1, "w12_sgn", 64'h08000);
        run_op(1'b1, 12'hFFF, 5'h1F, 1'b0, "w12_uns", 64'h1EFE1);

        for (int i = 0; i < 12; i++) begin
            ca = 8'($urandom); cb = 8'($urandom); csm = 1'($urandom);
            run_op(1'b0, 64'(ca), 64'(cb), csm, "rnd8", model(ca, cb, csm, 8, 8));
        end
        for (int i = 0; i < 12; i++) begin
            logic [11:0] ra;
            logic [4:0]  rb;
            ra = 12'($urandom); rb = 5'($urandom); csm = 1'($urandom);
            run_op(1'b1, 64'(ra), 64'(rb), csm, "rnd12", model(ra, rb, csm, 12, 5));
        end

        // START held high with operands changing every cycle.
        @(negedge clk);
        ca = 8'($urandom); cb = 8'($urandom); csm = 1'($urandom);
        start8 = 1'b1; a8 = ca; b8 = cb; sm8 = csm;
        e1 = model(ca, cb, csm, 8, 8);
        e2 = '0;
        ends = 0;
        for (int lat = 0; lat <= 24; lat++) begin
            @(negedge clk);
            if (end8) ends++;
            if (lat == 9) begin
                check("held_end1", 64'(end8), 64'd1);
                check("held_s1", 64'(s8), e1);
            end
            if (lat == 10) check("held_idle", 64'(busy8), 64'd0);
            if (lat == 20) begin
                check("held_end2", 64'(end8), 64'd1);
                check("held_s2", 64'(s8), e2);
            end
            na = 8'($urandom); nb = 8'($urandom); nsm = 1'($urandom);
            a8 = na; b8 = nb; sm8 = nsm;
            if (lat == 10) e2 = model(na, nb, nsm, 8, 8);
            if (lat >= 20) start8 = 1'b0;
        end
        check("held_ends", 64'(ends), 64'd2);

        run_op(1'b0, -128, 127, 1'b1, "pre_rst", 64'hC080);

        // Reset lands on the edge closing the 4th CALC cycle.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'(-45); b8 = 8'd96; sm8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_s", 64'(s8), 64'd0);
        check("midrst_end", 64'(end8), 64'd0);
        check("midrst_busy", 64'(busy8), 64'd0);
        ends = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (end8) ends++;
        end
        check("midrst_noend", 64'(ends), 64'd0);
        run_op(1'b0, 45, 96, 1'b1, "post_rst", 64'h10E0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
